decode_pipe: RTL and testbench

Parametrised, registered successor of the single-cycle decode stage. It decodes one RV32I instruction per cycle into ALU, memory and writeback controls. It reads a parametrised register file, sign-extends the immediate to XLEN, and presents everything through a valid/ready-handshaked ID/EX output register. It also inserts a one-cycle bubble on load-use hazards against the instruction it holds, and supports a synchronous flush from the branch/exception logic.

---
 rtl/decode_pipe.sv | 179 +++++++++++++++++
 tb/tb_decode_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// Registered RV32I decode stage: control decode, register file, immediate, load-use bubble and an ID/EX output register.
// Optional macro DECODE_WB_BYPASS_EN: forward same-cycle writeback data onto the read ports.

module control_unit (
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       alt_i,
  output logic       has_imm_o,
  output logic       alu_alt_o,
  output logic       rf_we_o,
  output logic       mem_we_o,
  output logic       mem2rf_o,
  output logic [2:0] alu_op_o
);
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  always_comb begin
    has_imm_o = 1'b0;
    alu_alt_o = 1'b0;
    rf_we_o   = 1'b0;
    mem_we_o  = 1'b0;
    mem2rf_o  = 1'b0;
    alu_op_o  = 3'd0;
    case (opcode_i)
      OPC_OP: begin
        rf_we_o   = 1'b1;
        alu_op_o  = funct3_i;
        alu_alt_o = alt_i;
      end
      OPC_IMM: begin
        rf_we_o   = 1'b1;
        has_imm_o = 1'b1;
        alu_op_o  = funct3_i;
        // only SRAI uses bit 30; for other immediates it is an immediate bit
        alu_alt_o = (funct3_i == 3'b101) && alt_i;
      end
      OPC_LOAD: begin
        rf_we_o   = 1'b1;
        has_imm_o = 1'b1;
        mem2rf_o  = 1'b1;
      end
      OPC_STORE: begin
        has_imm_o = 1'b1;
        mem_we_o  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

module decode_pipe #(
  parameter int XLEN    = 32,
  parameter int REG_CNT = 32,
  localparam int AW     = $clog2(REG_CNT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic            flush_i,
  input  logic            rf_we_i,
  input  logic [AW-1:0]   rf_waddr_i,
  input  logic [XLEN-1:0] rf_wdata_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic            has_imm_o,
  output logic            alu_alt_o,
  output logic            rf_we_o,
  output logic            mem_we_o,
  output logic            mem2rf_o,
  output logic [2:0]      alu_op_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] rf_data0_o,
  output logic [XLEN-1:0] rf_data1_o,
  output logic [AW-1:0]   rf_waddr_o,
  output logic            stall_o
);
  typedef struct packed {
    logic            has_imm;
    logic            alu_alt;
    logic            rf_we;
    logic            mem_we;
    logic            mem2rf;
    logic [2:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    logic [AW-1:0]   waddr;
  } idex_t;

  idex_t idex_q, idex_d;
  logic  out_valid_q;

  logic [REG_CNT-1:0][XLEN-1:0] rf_q;

  logic [AW-1:0]   rs0, rs1;
  logic [11:0]     imm12;
  logic [XLEN-1:0] rd0, rd1;
  logic            use_rs1, hazard, accept;

  control_unit u_ctrl (
    .opcode_i  (instr_i[6:0]),
    .funct3_i  (instr_i[14:12]),
    .alt_i     (instr_i[30]),
    .has_imm_o (idex_d.has_imm),
    .alu_alt_o (idex_d.alu_alt),
    .rf_we_o   (idex_d.rf_we),
    .mem_we_o  (idex_d.mem_we),
    .mem2rf_o  (idex_d.mem2rf),
    .alu_op_o  (idex_d.alu_op)
  );

  assign rs0   = instr_i[15 +: AW];
  assign rs1   = instr_i[20 +: AW];
  assign imm12 = idex_d.mem_we ? {instr_i[31:25], instr_i[11:7]} : instr_i[31:20];

  always_comb begin
    rd0 = rf_q[rs0];
    rd1 = rf_q[rs1];
`ifdef DECODE_WB_BYPASS_EN
    if (rf_we_i && (rf_waddr_i != '0) && (rf_waddr_i == rs0)) rd0 = rf_wdata_i;
    if (rf_we_i && (rf_waddr_i != '0) && (rf_waddr_i == rs1)) rd1 = rf_wdata_i;
`endif
    if (rs0 == '0) rd0 = '0;
    if (rs1 == '0) rd1 = '0;
  end

  assign idex_d.imm   = {{(XLEN-12){imm12[11]}}, imm12};
  assign idex_d.d0    = rd0;
  assign idex_d.d1    = rd1;
  assign idex_d.waddr = instr_i[7 +: AW];

  // Load in ID/EX whose rd feeds the incoming instruction: hold it back one cycle
  assign use_rs1 = !idex_d.has_imm || idex_d.mem_we;
  assign hazard  = in_valid_i && out_valid_q && idex_q.mem2rf && (idex_q.waddr != '0) &&
                   ((idex_q.waddr == rs0) || (use_rs1 && (idex_q.waddr == rs1)));

  assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign stall_o    = hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q <= '0;
    end else if (rf_we_i && (rf_waddr_i != '0)) begin
      rf_q[rf_waddr_i] <= rf_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      idex_q      <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      idex_q      <= idex_d;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid_o = out_valid_q;
  assign has_imm_o   = idex_q.has_imm;
  assign alu_alt_o   = idex_q.alu_alt;
  assign rf_we_o     = idex_q.rf_we;
  assign mem_we_o    = idex_q.mem_we;
  assign mem2rf_o    = idex_q.mem2rf;
  assign alu_op_o    = idex_q.alu_op;
  assign imm_o       = idex_q.imm;
  assign rf_data0_o  = idex_q.d0;
  assign rf_data1_o  = idex_q.d1;
  assign rf_waddr_o  = idex_q.waddr;
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i, in_ready_o, flush_i, rf_we_i, out_valid_o, out_ready_i;
  logic [31:0] instr_i, rf_wdata_i, imm_o, rf_data0_o, rf_data1_o;
  logic [4:0]  rf_waddr_i, rf_waddr_o;
  logic        has_imm_o, alu_alt_o, rf_we_o, mem_we_o, mem2rf_o, stall_o;
  logic [2:0]  alu_op_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .REG_CNT(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .flush_i(flush_i), .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
    .rf_wdata_i(rf_wdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .has_imm_o(has_imm_o), .alu_alt_o(alu_alt_o), .rf_we_o(rf_we_o), .mem_we_o(mem_we_o),
    .mem2rf_o(mem2rf_o), .alu_op_o(alu_op_o), .imm_o(imm_o), .rf_data0_o(rf_data0_o),
    .rf_data1_o(rf_data1_o), .rf_waddr_o(rf_waddr_o), .stall_o(stall_o)
  );

  typedef struct {
    bit        v;
    bit        hi, alt, we, mw, m2r;
    bit [2:0]  op;
    bit [31:0] imm, d0, d1;
    bit [4:0]  wa;
  } mh_t;

  mh_t       m_held;
  bit [31:0] m_rf [32];
  bit        m_rdy, m_haz;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mh_t m_decode(input bit [31:0] ins);
    mh_t r;
    int  v12;
    r = '{default: 0};
    r.v = 1;
    case (ins[6:0])
      7'h33: begin r.we = 1; r.op = ins[14:12]; r.alt = ins[30]; end
      7'h13: begin r.we = 1; r.hi = 1; r.op = ins[14:12]; r.alt = (ins[14:12] == 5) && ins[30]; end
      7'h03: begin r.we = 1; r.hi = 1; r.m2r = 1; end
      7'h23: begin r.hi = 1; r.mw = 1; end
      default: ;
    endcase
    v12 = r.mw ? int'({ins[31:25], ins[11:7]}) : int'(ins[31:20]);
    if (v12 >= 2048) v12 -= 4096;
    r.imm = v12;
    r.wa  = ins[11:7];
    return r;
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] a);
    if (a == 0) return 0;
`ifdef DECODE_WB_BYPASS_EN
    if (rf_we_i && rf_waddr_i == a) return rf_wdata_i;
`endif
    return m_rf[a];
  endfunction

  task automatic m_reset();
    m_held = '{default: 0};
    foreach (m_rf[i]) m_rf[i] = 0;
  endtask

  task automatic step(input bit vin, input bit [31:0] ins, input bit fl, input bit we,
                      input bit [4:0] wa, input bit [31:0] wd, input bit ordy);
    mh_t d;
    @(negedge clk);
    in_valid_i = vin; instr_i = ins; flush_i = fl;
    rf_we_i = we; rf_waddr_i = wa; rf_wdata_i = wd; out_ready_i = ordy;
    #1;
    d = m_decode(ins);
    d.d0 = m_read(ins[19:15]);
    d.d1 = m_read(ins[24:20]);
    m_haz = vin && m_held.v && m_held.m2r && m_held.wa != 0 &&
            (m_held.wa == ins[19:15] || ((!d.hi || d.mw) && m_held.wa == ins[24:20]));
    m_rdy = (!m_held.v || ordy) && !m_haz && !fl;
    chk("in_ready", in_ready_o, m_rdy);
    chk("stall", stall_o, m_haz);
    @(posedge clk);
    if (fl) m_held.v = 0;
    else if (vin && m_rdy) m_held = d;
    else if (ordy) m_held.v = 0;
    if (we && wa != 0) m_rf[wa] = wd;
    #1;
    chk("out_valid", out_valid_o, m_held.v);
    chk("has_imm", has_imm_o, m_held.hi);
    chk("alu_alt", alu_alt_o, m_held.alt);
    chk("rf_we", rf_we_o, m_held.we);
    chk("mem_we", mem_we_o, m_held.mw);
    chk("mem2rf", mem2rf_o, m_held.m2r);
    chk("alu_op", alu_op_o, m_held.op);
    chk("imm", imm_o, m_held.imm);
    chk("rf_data0", rf_data0_o, m_held.d0);
    chk("rf_data1", rf_data1_o, m_held.d1);
    chk("rf_waddr", rf_waddr_o, m_held.wa);
  endtask

  localparam bit [31:0] ADDI_X6  = 32'hFFF28313;
  localparam bit [31:0] SW_X7    = 32'hFE712E23;
  localparam bit [31:0] LW_X8    = 32'h0000A403;
  localparam bit [31:0] ADD_X9   = 32'h003404B3;
  localparam bit [31:0] ADDI_X9  = 32'h00800493;
  localparam bit [31:0] ADDI_X10 = 32'h00020513;
  localparam bit [31:0] ADDI_X11 = 32'h00000593;

  initial begin
    logic [31:0] snap_imm, snap_d0;
    logic [4:0]  snap_wa;
    bit   [31:0] ins;
    bit   [6:0]  opc [4] = '{7'h33, 7'h13, 7'h03, 7'h23};

    rst_n = 1'b0; in_valid_i = 0; instr_i = 0; flush_i = 0; rf_we_i = 0;
    rf_waddr_i = 0; rf_wdata_i = 0; out_ready_i = 0;
    m_reset();
    #2;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_payload", {imm_o, rf_data0_o}, 0);
    chk("rst_rf_waddr", rf_waddr_o, 0);
    @(negedge clk); rst_n = 1'b1;

    // writeback then addi reading it
    step(0, 0, 0, 1, 5, 32'h1234, 1);
    step(1, ADDI_X6, 0, 0, 0, 0, 1);
    chk("addi_valid", out_valid_o, 1);
    chk("addi_d0", rf_data0_o, 32'h1234);
    chk("addi_imm", imm_o, 32'hFFFFFFFF);
    chk("addi_has_imm", has_imm_o, 1);
    chk("addi_rd", rf_waddr_o, 6);

    step(1, SW_X7, 0, 0, 0, 0, 1);
    chk("sw_imm", imm_o, 32'hFFFFFFFC);
    chk("sw_mem_we", mem_we_o, 1);

    // back-pressure
    snap_imm = imm_o; snap_d0 = rf_data0_o; snap_wa = rf_waddr_o;
    for (int i = 0; i < 3; i++) begin
      step(1, ADDI_X10, 0, 0, 0, 0, 0);
      chk("bp_ready", in_ready_o, 0);
      chk("bp_stable", {snap_imm, snap_d0, 27'd0, snap_wa}, {imm_o, rf_data0_o, 27'd0, rf_waddr_o});
    end
    step(1, ADDI_X10, 0, 0, 0, 0, 1);
    chk("bp_release_rd", rf_waddr_o, 10);

    // load-use
    step(1, LW_X8, 0, 0, 0, 0, 1);
    step(1, ADD_X9, 0, 0, 0, 0, 1);
    chk("lu_bubble", out_valid_o, 0);
    step(1, ADD_X9, 0, 0, 0, 0, 1);
    chk("lu_issue_valid", out_valid_o, 1);
    chk("lu_issue_rd", rf_waddr_o, 9);

    // rs1 field matches but is an immediate
    step(1, LW_X8, 0, 0, 0, 0, 1);
    step(1, ADDI_X9, 0, 0, 0, 0, 1);
    chk("noh_valid", out_valid_o, 1);
    chk("noh_imm", imm_o, 8);

    // flush
    step(1, ADDI_X10, 0, 0, 0, 0, 0);
    step(1, LW_X8, 1, 0, 0, 0, 0);
    chk("flush_valid", out_valid_o, 0);
    step(0, LW_X8, 0, 0, 0, 0, 1);
    chk("flush_not_consumed", out_valid_o, 0);

    // same-cycle write/read
    step(1, ADDI_X10, 0, 1, 4, 32'hAA, 1);
`ifdef DECODE_WB_BYPASS_EN
    chk("wb_same_cycle", rf_data0_o, 32'hAA);
`else
    chk("wb_same_cycle", rf_data0_o, 32'h0);
`endif
    step(1, ADDI_X10, 0, 0, 0, 0, 1);
    chk("wb_next_cycle", rf_data0_o, 32'hAA);

    // x0 stays zero
    step(0, 0, 0, 1, 0, 32'hFFFF, 1);
    step(1, ADDI_X11, 0, 0, 0, 0, 1);
    chk("x0_read", rf_data0_o, 0);

    for (int n = 0; n < 600; n++) begin
      ins = $urandom;
      ins[6:0]   = opc[$urandom_range(0, 3)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 7);
    end

    // asynchronous reset mid-operation
    step(1, LW_X8, 0, 0, 0, 0, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid_o, 0);
    chk("async_rst_imm", imm_o, 0);
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    step(1, ADDI_X6, 0, 0, 0, 0, 1);
    chk("post_rst_rf", rf_data0_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
